// File: rtl/rd_showahead_adapter_pkg.sv
// Shared definitions for the read side of the dual-clock FIFO.
//   RD_LATENCY : cycles from an accepted read to valid RAM data
//   cnt_width  : bits needed to hold a count of 0..depth
package rd_showahead_adapter_pkg;

    localparam int unsigned RD_LATENCY = 1;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_showahead_adapter_reg_queue.sv
// Small register FIFO that holds the words already read from the RAM.
// Ports:
//   rd_clk_i, rd_srst_n_i : clock, synchronous active-low reset
//   wr_en_i, wr_data_i    : push a word into the tail slot
//   rd_en_i               : drop the head word
//   head_o                : head word, straight from a storage register
//   count_o               : words currently stored
// There is no overflow/underflow protection: the caller guarantees space on
// write and a non-empty queue on read.
module rd_showahead_adapter_reg_queue
    import rd_showahead_adapter_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                          rd_clk_i,
    input  logic                          rd_srst_n_i,
    input  logic                          wr_en_i,
    input  logic [DWIDTH-1:0]             wr_data_i,
    input  logic                          rd_en_i,
    output logic [DWIDTH-1:0]             head_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;

    // Pointers are mod-DEPTH counters.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rd_clk_i) begin
        if (!rd_srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_en_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rd_showahead_adapter.sv
// Converts the FIFO's normal-mode read port (request, registered empty, data
// one cycle after an accepted read) into a show-ahead valid/ready stream.
// Ports:
//   rd_clk_i, rd_srst_n_i : read clock, synchronous active-low reset
//   fifo_empty_i          : registered empty flag from the read-pointer stage
//   fifo_rd_req_o         : read request to the read-pointer stage
//   fifo_q_i              : RAM read data, valid one cycle after an accept
//   out_data_o/out_valid_o/out_ready_i : show-ahead output stream
//   level_o               : words stored locally
// The request depends only on registers and reset, so there is no
// combinational path from out_ready_i to fifo_rd_req_o.
module rd_showahead_adapter
    import rd_showahead_adapter_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned BUF_DEPTH = 3
) (
    input  logic                              rd_clk_i,
    input  logic                              rd_srst_n_i,
    input  logic                              fifo_empty_i,
    output logic                              fifo_rd_req_o,
    input  logic [DWIDTH-1:0]                 fifo_q_i,
    output logic [DWIDTH-1:0]                 out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [cnt_width(BUF_DEPTH)-1:0]   level_o
);

    localparam int unsigned CW = cnt_width(BUF_DEPTH);
    localparam int unsigned OW = CW + 1;

    if (BUF_DEPTH < 3) begin : g_bad_depth
        $error("BUF_DEPTH below 3 cannot sustain one word per cycle");
    end
    if (RD_LATENCY != 1) begin : g_bad_latency
        $error("single-stage inflight tracking assumes a 1-cycle RAM read");
    end

    logic          inflight_q;
    logic          accept;
    logic          pop;
    logic [CW-1:0] cnt;
    logic [OW-1:0] outstanding;

    // Stored plus in-flight words never exceed the local storage, so the
    // unconditional capture below can never overwrite a live entry.
    assign outstanding   = {1'b0, cnt} + {{CW{1'b0}}, inflight_q};
    assign fifo_rd_req_o = rd_srst_n_i & (outstanding < OW'(BUF_DEPTH));
    assign accept        = fifo_rd_req_o & ~fifo_empty_i;
    assign out_valid_o   = (cnt != '0);
    assign pop           = out_valid_o & out_ready_i;
    assign level_o       = cnt;

    always_ff @(posedge rd_clk_i) begin
        if (!rd_srst_n_i) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
        end
    end

    rd_showahead_adapter_reg_queue #(
        .DWIDTH (DWIDTH),
        .DEPTH  (BUF_DEPTH)
    ) u_reg_queue (
        .rd_clk_i    (rd_clk_i),
        .rd_srst_n_i (rd_srst_n_i),
        .wr_en_i     (inflight_q),
        .wr_data_i   (fifo_q_i),
        .rd_en_i     (pop),
        .head_o      (out_data_o),
        .count_o     (cnt)
    );

endmodule

// File: tb/tb_rd_showahead_adapter.sv
// Directed bench for rd_showahead_adapter with a small upstream FIFO model
// (registered empty, data one cycle after an accepted read).
module tb_rd_showahead_adapter;

    logic       rd_clk_i;
    logic       rd_srst_n_i;
    logic       fifo_empty_i;
    logic       fifo_rd_req_o;
    logic [7:0] fifo_q_i;
    logic [7:0] out_data_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [1:0] level_o;

    rd_showahead_adapter #(
        .DWIDTH    (8),
        .BUF_DEPTH (3)
    ) dut (
        .rd_clk_i      (rd_clk_i),
        .rd_srst_n_i   (rd_srst_n_i),
        .fifo_empty_i  (fifo_empty_i),
        .fifo_rd_req_o (fifo_rd_req_o),
        .fifo_q_i      (fifo_q_i),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .level_o       (level_o)
    );

    initial rd_clk_i = 1'b0;
    always #5 rd_clk_i = ~rd_clk_i;

    typedef struct {
        logic       ready;
        logic       hold;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_level;
        logic       exp_req;
    } vec_t;

    vec_t       vecs [19];
    logic [7:0] up_q [$];
    logic [7:0] exp_q [$];
    logic       hold_empty;
    logic       sb_en;
    logic       acc_s;
    int         n_tests;
    int         n_fail;
    int         pops;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = hold_empty || (up_q.size() == 0);
    endtask

    // Sample the DUT mid-cycle, away from the active edge.
    task automatic at_negedge();
        logic [7:0] e;
        @(negedge rd_clk_i);
        acc_s = fifo_rd_req_o & ~fifo_empty_i;
        if (sb_en && out_valid_o && out_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {24'd0, out_data_o}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", {24'd0, out_data_o}, {24'd0, e});
            end
        end
    endtask

    // Upstream model: an accepted read returns data after the edge; data is
    // junk otherwise so that a spurious capture shows up.
    task automatic after_posedge();
        @(posedge rd_clk_i);
        #1;
        if (acc_s && up_q.size() != 0) fifo_q_i = up_q.pop_front();
        else fifo_q_i = 8'hEE;
        refresh();
    endtask

    task automatic tick();
        at_negedge();
        after_posedge();
    endtask

    task automatic set_vec(input int i, input logic r, input logic h, input logic v,
                           input logic [7:0] d, input logic [1:0] l, input logic q);
        vecs[i].ready     = r;
        vecs[i].hold      = h;
        vecs[i].exp_valid = v;
        vecs[i].exp_data  = d;
        vecs[i].exp_level = l;
        vecs[i].exp_req   = q;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            out_ready_i = vecs[i].ready;
            hold_empty  = vecs[i].hold;
            refresh();
            at_negedge();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_level", i), {30'd0, level_o}, {30'd0, vecs[i].exp_level});
            check($sformatf("vec%0d_req", i), {31'd0, fifo_rd_req_o}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), {24'd0, out_data_o}, {24'd0, vecs[i].exp_data});
            after_posedge();
        end
    endtask

    initial begin
        int  first_v;
        int  gaps;
        bit  seen;

        n_tests = 0;
        n_fail  = 0;
        pops    = 0;
        sb_en   = 1'b0;

        // Latency segment: rows 0..5, ready held high.
        set_vec(0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        set_vec(1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        set_vec(2, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1);
        set_vec(3, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1);
        set_vec(4, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1);
        set_vec(5, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        // Backpressure segment: rows 6..18, ready low until row 12.
        set_vec(6,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        set_vec(7,  1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);
        set_vec(8,  1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 1'b1);
        set_vec(9,  1'b0, 1'b0, 1'b1, 8'h00, 2'd2, 1'b0);
        set_vec(10, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0);
        set_vec(11, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0);
        set_vec(12, 1'b1, 1'b0, 1'b1, 8'h00, 2'd3, 1'b0);
        set_vec(13, 1'b1, 1'b0, 1'b1, 8'h01, 2'd2, 1'b1);
        set_vec(14, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1, 1'b1);
        set_vec(15, 1'b1, 1'b0, 1'b1, 8'h03, 2'd1, 1'b1);
        set_vec(16, 1'b1, 1'b0, 1'b1, 8'h04, 2'd1, 1'b1);
        set_vec(17, 1'b1, 1'b0, 1'b1, 8'h05, 2'd1, 1'b1);
        set_vec(18, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1);

        // Reset with a non-empty FIFO: nothing may be requested.
        rd_srst_n_i = 1'b0;
        out_ready_i = 1'b1;
        fifo_q_i    = 8'hEE;
        hold_empty  = 1'b0;
        up_q.push_back(8'h5A);
        refresh();
        for (int i = 0; i < 3; i++) begin
            at_negedge();
            check("rst_req", {31'd0, fifo_rd_req_o}, 32'd0);
            check("rst_valid", {31'd0, out_valid_o}, 32'd0);
            check("rst_level", {30'd0, level_o}, 32'd0);
            check("rst_data", {24'd0, out_data_o}, 32'd0);
            after_posedge();
        end
        rd_srst_n_i = 1'b1;
        hold_empty  = 1'b1;
        up_q.delete();
        refresh();
        tick();
        tick();

        // Latency.
        up_q = '{8'h11, 8'h22, 8'h33};
        run_vecs(0, 5);

        // Backpressure then release.
        hold_empty = 1'b1;
        for (int w = 0; w < 6; w++) up_q.push_back(8'(w));
        refresh();
        tick();
        run_vecs(6, 18);

        // Throughput: 16 words with ready held high.
        sb_en      = 1'b1;
        hold_empty = 1'b1;
        pops       = 0;
        for (int w = 0; w < 16; w++) begin
            up_q.push_back(8'(w));
            exp_q.push_back(8'(w));
        end
        out_ready_i = 1'b1;
        hold_empty  = 1'b0;
        refresh();
        first_v = -1;
        gaps    = 0;
        seen    = 1'b0;
        for (int c = 0; c < 30; c++) begin
            at_negedge();
            if (out_valid_o) begin
                if (!seen) first_v = c;
                seen = 1'b1;
            end else if (seen && pops < 16) begin
                gaps++;
            end
            after_posedge();
        end
        check("thru_pops", pops, 32'd16);
        check("thru_gaps", gaps, 32'd0);
        check("thru_first_valid", first_v, 32'd2);
        check("thru_leftover", exp_q.size(), 32'd0);

        // Empty mid-stream: two words then a late refill.
        pops       = 0;
        hold_empty = 1'b1;
        up_q       = '{8'hA0, 8'hA1};
        exp_q      = '{8'hA0, 8'hA1};
        refresh();
        tick();
        hold_empty = 1'b0;
        refresh();
        for (int c = 0; c < 8; c++) tick();
        check("empty_pops", pops, 32'd2);
        sb_en = 1'b0;
        at_negedge();
        check("empty_valid_low", {31'd0, out_valid_o}, 32'd0);
        after_posedge();
        up_q.push_back(8'hA2);
        refresh();
        at_negedge();
        check("refill_n_valid", {31'd0, out_valid_o}, 32'd0);
        after_posedge();
        at_negedge();
        check("refill_n1_valid", {31'd0, out_valid_o}, 32'd0);
        after_posedge();
        at_negedge();
        check("refill_n2_valid", {31'd0, out_valid_o}, 32'd1);
        check("refill_n2_data", {24'd0, out_data_o}, 32'hA2);
        after_posedge();
        tick();

        // Reset mid-operation with two stored words and one in flight.
        out_ready_i = 1'b0;
        hold_empty  = 1'b1;
        up_q        = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        refresh();
        tick();
        hold_empty = 1'b0;
        refresh();
        tick();
        tick();
        tick();
        at_negedge();
        check("pre_rst_level", {30'd0, level_o}, 32'd2);
        check("pre_rst_inflight_req", {31'd0, fifo_rd_req_o}, 32'd0);
        after_posedge();
        rd_srst_n_i = 1'b0;
        at_negedge();
        after_posedge();
        up_q.delete();
        hold_empty = 1'b1;
        refresh();
        at_negedge();
        check("mid_rst_level", {30'd0, level_o}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        after_posedge();
        rd_srst_n_i = 1'b1;
        tick();
        tick();
        check("post_rst_no_ghost", {31'd0, out_valid_o}, 32'd0);
        sb_en       = 1'b1;
        pops        = 0;
        out_ready_i = 1'b1;
        up_q        = '{8'hC0};
        exp_q       = '{8'hC0};
        hold_empty  = 1'b0;
        refresh();
        for (int c = 0; c < 8; c++) tick();
        check("post_rst_pops", pops, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
